// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Shadow entry layout, forwarding select codes, default zero register.
package hazard_pkg;

  localparam int unsigned RW_MAX = 8;
  localparam int unsigned ZERO_REG_DEFAULT = 31;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [RW_MAX-1:0] rd;
    logic              is_load;
  } shadow_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Finds the youngest in-flight producer of one source register.
// Ports: shadow (examined stages), src -> hit, idx, is_load.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int RW       = 5,
  parameter int ZERO_REG = 31
) (
  input  shadow_entry_t [DEPTH-2:0]  shadow,
  input  logic [RW-1:0]              src,
  output logic                       hit,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic                       is_load
);

  localparam int IW = $clog2(DEPTH);

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = DEPTH-2; k >= 0; k--) begin
      if (shadow[k].valid &&
          shadow[k].rd == RW_MAX'(src) &&
          src != RW'(ZERO_REG)) begin
        hit     = 1'b1;
        idx     = IW'(k);
        is_load = shadow[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: stall/forward decision, EX fwd selects.
// Ports: ID operands in, PCWrite/IF_ID_Write/stall, fwd_a/b, stat counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int RW           = $clog2(NREGS),
  parameter int ZERO_REG     = ZERO_REG_DEFAULT,
  parameter int DEPTH        = 3,
  parameter int LOAD_STAGE   = 1,
  parameter int FLUSH_STAGES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     id_valid,
  input  logic [RW-1:0]            id_ra1,
  input  logic [RW-1:0]            id_ra2,
  input  logic [RW-1:0]            id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     fwd_en,
  input  logic                     flush,
  output logic                     PCWrite,
  output logic                     IF_ID_Write,
  output logic                     stall,
  output logic [$clog2(DEPTH)-1:0] fwd_a,
  output logic [$clog2(DEPTH)-1:0] fwd_b,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         loaduse_stalls
);

  localparam int IW   = $clog2(DEPTH);
  localparam int NCHK = DEPTH - 1;

  // WB never hazards (write-through regfile), so only EX..WB-1 are kept.
  shadow_entry_t [NCHK-1:0] sh_q;
  shadow_entry_t [NCHK-1:0] sh_d;

  logic          hit_a, hit_b;
  logic [IW-1:0] idx_a, idx_b;
  logic          ld_a, ld_b;
  logic          haz_a, haz_b;
  logic          hazard;
  logic [IW-1:0] fa_d, fb_d;

  hazard_src_match #(
    .DEPTH(DEPTH), .RW(RW), .ZERO_REG(ZERO_REG)
  ) u_match_a (
    .shadow(sh_q), .src(id_ra1),
    .hit(hit_a), .idx(idx_a), .is_load(ld_a)
  );

  hazard_src_match #(
    .DEPTH(DEPTH), .RW(RW), .ZERO_REG(ZERO_REG)
  ) u_match_b (
    .shadow(sh_q), .src(id_ra2),
    .hit(hit_b), .idx(idx_b), .is_load(ld_b)
  );

  // With forwarding only a load not yet at its data stage blocks.
  always_comb begin
    if (fwd_en) begin
      haz_a = hit_a && ld_a && (int'(idx_a) < LOAD_STAGE);
      haz_b = hit_b && ld_b && (int'(idx_b) < LOAD_STAGE);
    end else begin
      haz_a = hit_a;
      haz_b = hit_b;
    end
  end

  assign hazard      = id_valid && (haz_a || haz_b);
  assign stall       = hazard && !flush;
  assign PCWrite     = !stall;
  assign IF_ID_Write = !stall;

  always_comb begin
    sh_d = '0;
    if (id_valid && !stall && !flush) begin
      sh_d[0].valid   = id_regwrite && (id_rd != RW'(ZERO_REG));
      sh_d[0].rd      = RW_MAX'(id_rd);
      sh_d[0].is_load = id_memread;
    end
    for (int k = 1; k < NCHK; k++) begin
      if (flush && k <= FLUSH_STAGES) sh_d[k] = '0;
      else                            sh_d[k] = sh_q[k-1];
    end
  end

  // Select = producer's stage when the consumer reaches EX.
  always_comb begin
    fa_d = IW'(FWD_RF);
    fb_d = IW'(FWD_RF);
    if (fwd_en && !stall && !flush) begin
      if (hit_a) fa_d = idx_a + IW'(1);
      if (hit_b) fb_d = idx_b + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q           <= '0;
      fwd_a          <= '0;
      fwd_b          <= '0;
      stall_cycles   <= '0;
      loaduse_stalls <= '0;
    end else begin
      sh_q  <= sh_d;
      fwd_a <= fa_d;
      fwd_b <= fb_d;
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (stall && fwd_en && loaduse_stalls != '1)
        loaduse_stalls <= loaduse_stalls + 1'b1;
    end
  end

endmodule
